fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/fifo_rd_ctrl_sync_obuf.sv | 58 +++++
 rtl/fifo_rd_ctrl.sv | 136 +++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the async FIFO read-side controller.
// Holds the FSM encoding and the counter width function.
package fifo_rd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int OBUF_DEPTH_DEF = 4;
    localparam int CNT_W = clog2(OBUF_DEPTH_DEF + 1);

endpackage

// File: rtl/fifo_rd_ctrl_sync_obuf.sv
// Small single-clock FIFO that holds read words until downstream accepts.
// The head entry is always visible on dout; cnt reports occupancy.
module sync_obuf
    import fifo_rd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 9,
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          vld,
    output logic [CW-1:0] cnt
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] A_ONE    = AW'(1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign vld    = (cnt != '0);
    assign do_pop = pop && vld;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + A_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + A_ONE;
            end
            if (push && !do_pop) cnt <= cnt + C_ONE;
            else if (!push && do_pop) cnt <= cnt - C_ONE;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && cnt == C_FULL)
    );

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: pulls bursts from an async FIFO with credit
// gating and streams them downstream as valid/ready with a last flag.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 7,
    parameter int RD_LAT     = 1,
    parameter int BURST_LEN  = 4,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic              rdclk,
    input  logic              rst,
    input  logic              rdempty,
    input  logic [ADDR_W-1:0] rdusedw,
    input  logic [DATA_W-1:0] rddout,
    input  logic              flush,
    output logic              rdreq,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_last,
    input  logic              dout_rdy,
    output logic              busy
);

    localparam int OCW = clog2(OBUF_DEPTH + 1);
    localparam int SW  = OCW + 2;
    localparam logic [ADDR_W-1:0] BL    = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [SW-1:0]     OD    = SW'(OBUF_DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] beat_cnt;
    logic [ADDR_W-1:0] beat_nx;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] target_nx;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] last_pipe;
    logic [OCW-1:0]    inflight;
    logic [OCW-1:0]    obuf_cnt;
    logic              credit_ok;
    logic              issue_last;
    logic [DATA_W:0]   obuf_head;
    logic              obuf_vld;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCW'(vld_pipe[i]);
        end
    end

    // Tags in flight already own a buffer slot, so they count as credit used.
    assign credit_ok = (SW'(obuf_cnt) + SW'(inflight)) < OD;

    always_comb begin
        state_nx   = state;
        beat_nx    = beat_cnt;
        target_nx  = target;
        rdreq      = 1'b0;
        issue_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (rdusedw >= BL) begin
                    state_nx  = BURST;
                    beat_nx   = '0;
                    target_nx = BL;
                end else if (flush && !rdempty) begin
                    state_nx  = BURST;
                    beat_nx   = '0;
                    target_nx = (rdusedw == '0) ? A_ONE : rdusedw;
                end
            end
            BURST: begin
                rdreq = !rdempty && credit_ok && (beat_cnt < target);
                if (rdreq) begin
                    beat_nx    = beat_cnt + A_ONE;
                    issue_last = (beat_nx == target);
                    if (issue_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge rdclk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            target    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_nx;
            target   <= target_nx;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            vld_pipe[0]  <= rdreq;
            last_pipe[0] <= issue_last;
        end
    end

    sync_obuf #(
        .DEPTH (OBUF_DEPTH),
        .W     (DATA_W + 1),
        .CW    (OCW)
    ) u_obuf (
        .clk  (rdclk),
        .rst  (rst),
        .push (vld_pipe[RD_LAT-1]),
        .din  ({last_pipe[RD_LAT-1], rddout}),
        .pop  (dout_vld && dout_rdy),
        .dout (obuf_head),
        .vld  (obuf_vld),
        .cnt  (obuf_cnt)
    );

    assign dout      = obuf_head[DATA_W-1:0];
    assign dout_vld  = obuf_vld;
    assign dout_last = obuf_vld && obuf_head[DATA_W];
    assign busy      = (state == BURST) || (inflight != '0);

    a_credit: assert property (
        @(posedge rdclk) disable iff (rst)
        (SW'(obuf_cnt) + SW'(inflight) + SW'(rdreq)) <= OD
    );

    a_no_read_empty: assert property (
        @(posedge rdclk) disable iff (rst) !(rdreq && rdempty)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with a queue-based async FIFO model.
module tb_fifo_rd_ctrl;

    logic       rdclk;
    logic       rst;
    logic       rdempty;
    logic [6:0] rdusedw;
    logic [7:0] rddout;
    logic       flush;
    logic       rdreq;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_last;
    logic       dout_rdy;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int viol   = 0;
    int n_put  = 0;
    bit chk_en = 1'b1;

    logic [8:0] exp_q[$];
    logic [7:0] fq[$];
    logic       mdl_empty   = 1'b1;
    logic       force_empty = 1'b0;

    fifo_rd_ctrl dut (
        .rdclk     (rdclk),
        .rst       (rst),
        .rdempty   (rdempty),
        .rdusedw   (rdusedw),
        .rddout    (rddout),
        .flush     (flush),
        .rdreq     (rdreq),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_last (dout_last),
        .dout_rdy  (dout_rdy),
        .busy      (busy)
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    assign rdempty = mdl_empty | force_empty;

    initial begin
        rdusedw = '0;
        rddout  = '0;
    end

    // Non-showahead FIFO model: data appears the cycle after rdreq.
    always @(posedge rdclk) begin
        if (rdreq && fq.size() != 0) rddout <= fq.pop_front();
    end

    always begin
        @(posedge rdclk);
        #2;
        mdl_empty = (fq.size() == 0);
        rdusedw   = (fq.size() > 127) ? 7'd127 : 7'(fq.size());
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
        end
    endtask

    always @(negedge rdclk) begin
        if (rdreq && rdempty) viol++;
        if (!rst && chk_en && dout_vld && dout_rdy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL stream got=%0h expected=none",
                         {dout_last, dout});
            end else begin
                check("stream", {23'd0, dout_last, dout},
                      {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic put(input logic [7:0] d, input logic lst,
                       input bit expect_it);
        fq.push_back(d);
        if (expect_it) exp_q.push_back({lst, d});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge rdclk);
        #1;
    endtask

    task automatic watch(input int n, output int reqs, output int f_req,
                         output int l_req, output int f_vld);
        reqs  = 0;
        f_req = -1;
        l_req = -1;
        f_vld = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge rdclk);
            if (rdreq) begin
                reqs++;
                if (f_req < 0) f_req = i;
                l_req = i;
            end
            if (dout_vld && f_vld < 0) f_vld = i;
            @(posedge rdclk);
            #1;
        end
    endtask

    task automatic wait_req(input int lim, input string nm);
        int k;
        k = 0;
        @(negedge rdclk);
        while (!rdreq && k < lim) begin
            @(negedge rdclk);
            k++;
        end
        if (!rdreq) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s got=timeout expected=rdreq", nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs, f_req, l_req, f_vld, k;

        rst      = 1'b1;
        flush    = 1'b0;
        dout_rdy = 1'b1;
        cycles(3);
        check("rst_rdreq", 32'(rdreq), 0);
        check("rst_vld", 32'(dout_vld), 0);
        check("rst_last", 32'(dout_last), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        put(8'h11, 1'b0, 1'b1);
        put(8'h22, 1'b0, 1'b1);
        put(8'h33, 1'b0, 1'b1);
        put(8'h44, 1'b1, 1'b1);
        watch(15, reqs, f_req, l_req, f_vld);
        check("basic_reqs", 32'(reqs), 4);
        check("basic_consec", 32'(l_req - f_req), 3);
        check("basic_latency", 32'(f_vld - f_req), 2);
        check("basic_drained", 32'(exp_q.size()), 0);
        check("basic_busy", 32'(busy), 0);

        put(8'h51, 1'b0, 1'b1);
        put(8'h52, 1'b0, 1'b1);
        put(8'h53, 1'b1, 1'b1);
        watch(50, reqs, f_req, l_req, f_vld);
        check("thresh_hold", 32'(reqs), 0);
        flush = 1'b1;
        watch(12, reqs, f_req, l_req, f_vld);
        check("flush_reqs", 32'(reqs), 3);
        check("flush_consec", 32'(l_req - f_req), 2);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 0);
        check("flush_drained", 32'(exp_q.size()), 0);

        dout_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            put(8'(8'h60 + i), (i % 4) == 3, 1'b1);
        end
        watch(20, reqs, f_req, l_req, f_vld);
        check("bp_reqs", 32'(reqs), 4);
        check("bp_vld", 32'(dout_vld), 1);
        check("bp_head", 32'(dout), 32'h60);
        cycles(5);
        check("bp_hold", 32'(dout), 32'h60);
        dout_rdy = 1'b1;
        watch(60, reqs, f_req, l_req, f_vld);
        check("bp_resume_reqs", 32'(reqs), 16);
        check("bp_drained", 32'(exp_q.size()), 0);

        put(8'h71, 1'b0, 1'b1);
        put(8'h72, 1'b0, 1'b1);
        put(8'h73, 1'b0, 1'b1);
        put(8'h74, 1'b1, 1'b1);
        wait_req(20, "stall_start");
        @(posedge rdclk);
        #1;
        force_empty = 1'b1;
        watch(5, reqs, f_req, l_req, f_vld);
        check("stall_paused", 32'(reqs), 0);
        check("stall_busy", 32'(busy), 1);
        force_empty = 1'b0;
        watch(10, reqs, f_req, l_req, f_vld);
        check("stall_rest", 32'(reqs), 3);
        check("stall_drained", 32'(exp_q.size()), 0);

        chk_en = 1'b0;
        for (int i = 0; i < 8; i++) put(8'(8'h81 + i), 1'b0, 1'b0);
        wait_req(20, "rstmid_start");
        @(posedge rdclk);
        #1;
        @(negedge rdclk);
        check("rstmid_2nd", 32'(rdreq), 1);
        @(posedge rdclk);
        #1;
        rst = 1'b1;
        @(posedge rdclk);
        #1;
        check("rstmid_rdreq", 32'(rdreq), 0);
        check("rstmid_vld", 32'(dout_vld), 0);
        check("rstmid_busy", 32'(busy), 0);
        fq.delete();
        cycles(1);
        rst    = 1'b0;
        chk_en = 1'b1;
        put(8'h91, 1'b0, 1'b1);
        put(8'h92, 1'b0, 1'b1);
        watch(20, reqs, f_req, l_req, f_vld);
        check("rstmid_hold", 32'(reqs), 0);
        put(8'h93, 1'b0, 1'b1);
        put(8'h94, 1'b1, 1'b1);
        watch(15, reqs, f_req, l_req, f_vld);
        check("rstmid_fresh", 32'(reqs), 4);
        check("rstmid_drained", 32'(exp_q.size()), 0);

        n_put = 0;
        for (int c = 0; c < 10000; c++) begin
            dout_rdy    = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0 && fq.size() < 100) begin
                put(8'(n_put), (n_put % 4) == 3, 1'b1);
                n_put++;
            end
            cycles(1);
        end
        while ((n_put % 4) != 0) begin
            put(8'(n_put), (n_put % 4) == 3, 1'b1);
            n_put++;
        end
        force_empty = 1'b0;
        dout_rdy    = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || busy || dout_vld) && k < 400) begin
            cycles(1);
            k++;
        end
        check("soak_drained", 32'(exp_q.size()), 0);
        check("soak_idle", 32'(busy), 0);
        check("no_read_empty", 32'(viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
